// File: rtl/rs_tag_allocator.sv
// Lowest-free tag allocator for the ALU reservation station and the LS buffer.
// Build option: TAG_ALLOC_CHECK_EN adds a sticky err flag for illegal alloc/release.

module rs_tag_unit #(
  parameter int RS_SIZE      = 15,
  parameter int ROOT_W       = 4,
  parameter int STALL_MARGIN = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_flush,
  input  logic              i_req,
  input  logic              i_rel_en,
  input  logic [ROOT_W-1:0] i_rel_root,
  output logic [ROOT_W-1:0] o_root,
  output logic              o_avail,
  output logic [ROOT_W-1:0] o_count,
  output logic              o_few_nxt,
  output logic              o_err
);
  logic [RS_SIZE-1:0] r_busy, w_busy_nxt;
  logic [ROOT_W-1:0]  r_root, r_count, w_root_nxt, w_cnt_nxt;
  logic               r_avail, w_avail_nxt;
  logic               w_alloc, w_rel_hit, w_rel_ok;

  assign w_alloc  = i_req & r_avail & ~i_flush;
  assign w_rel_ok = w_rel_hit & ~i_flush;

  // Out-of-range roots never match an index, so they fall out as ignored.
  always_comb begin
    w_rel_hit = 1'b0;
    for (int i = 0; i < RS_SIZE; i++)
      if (i_rel_en && i_rel_root == ROOT_W'(i) && r_busy[i]) w_rel_hit = 1'b1;
  end

  always_comb begin
    w_busy_nxt = r_busy;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (w_rel_ok && i_rel_root == ROOT_W'(i)) w_busy_nxt[i] = 1'b0;
      if (w_alloc && r_root == ROOT_W'(i))      w_busy_nxt[i] = 1'b1;
    end
    if (i_flush) w_busy_nxt = '0;
  end

  always_comb begin
    w_cnt_nxt = r_count;
    if (i_flush)                  w_cnt_nxt = '0;
    else if (w_alloc && !w_rel_ok) w_cnt_nxt = r_count + ROOT_W'(1);
    else if (!w_alloc && w_rel_ok) w_cnt_nxt = r_count - ROOT_W'(1);
  end

  // Scan downward so the lowest free index wins.
  always_comb begin
    w_root_nxt  = '1;
    w_avail_nxt = 1'b0;
    for (int i = RS_SIZE - 1; i >= 0; i--)
      if (!w_busy_nxt[i]) begin
        w_root_nxt  = ROOT_W'(i);
        w_avail_nxt = 1'b1;
      end
  end

  assign o_few_nxt = (RS_SIZE - int'(w_cnt_nxt)) < STALL_MARGIN;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy  <= '0;
      r_root  <= '0;
      r_avail <= 1'b1;
      r_count <= '0;
    end else begin
      r_busy  <= w_busy_nxt;
      r_root  <= w_root_nxt;
      r_avail <= w_avail_nxt;
      r_count <= w_cnt_nxt;
    end
  end

`ifdef TAG_ALLOC_CHECK_EN
  logic r_err;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_err <= 1'b0;
    else     r_err <= r_err | (i_req & ~r_avail) | (i_rel_en & ~w_rel_hit);
  end
  assign o_err = r_err;
`else
  assign o_err = 1'b0;
`endif

  assign o_root  = r_root;
  assign o_avail = r_avail;
  assign o_count = r_count;
endmodule

module rs_tag_allocator #(
  parameter int RS_SIZE      = 15,
  parameter int ROOT_W       = 4,
  parameter int STALL_MARGIN = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alloc_req,
  input  logic              alloc_is_ls,
  input  logic              alu_rel_en,
  input  logic [ROOT_W-1:0] alu_rel_root,
  input  logic              ls_rel_en,
  input  logic [ROOT_W-1:0] ls_rel_root,
  input  logic              flush,
  output logic [ROOT_W:0]   alu_free_tag,
  output logic [ROOT_W:0]   ls_free_tag,
  output logic              alu_avail,
  output logic              ls_avail,
  output logic              alloc_ok,
  output logic [ROOT_W-1:0] alu_count,
  output logic [ROOT_W-1:0] ls_count,
  output logic              stall,
  output logic              err
);
  localparam int NU = 2;  // unit 0 = ALU, unit 1 = LS

  logic [NU-1:0]             w_req, w_rel_en, w_avail, w_few, w_err;
  logic [NU-1:0][ROOT_W-1:0] w_rel_root, w_root, w_count;
  logic                      r_stall;

  assign w_req      = {alloc_req & alloc_is_ls, alloc_req & ~alloc_is_ls};
  assign w_rel_en   = {ls_rel_en, alu_rel_en};
  assign w_rel_root = {ls_rel_root, alu_rel_root};

  generate
    for (genvar g = 0; g < NU; g++) begin : g_unit
      rs_tag_unit #(
        .RS_SIZE(RS_SIZE), .ROOT_W(ROOT_W), .STALL_MARGIN(STALL_MARGIN)
      ) u_unit (
        .clk       (clk),
        .rst       (rst),
        .i_flush   (flush),
        .i_req     (w_req[g]),
        .i_rel_en  (w_rel_en[g]),
        .i_rel_root(w_rel_root[g]),
        .o_root    (w_root[g]),
        .o_avail   (w_avail[g]),
        .o_count   (w_count[g]),
        .o_few_nxt (w_few[g]),
        .o_err     (w_err[g])
      );
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_stall <= 1'b0;
    else     r_stall <= |w_few;
  end

  assign alloc_ok     = |(w_req & w_avail);
  assign alu_free_tag = {1'b0, w_root[0]};
  assign ls_free_tag  = {1'b1, w_root[1]};
  assign alu_avail    = w_avail[0];
  assign ls_avail     = w_avail[1];
  assign alu_count    = w_count[0];
  assign ls_count     = w_count[1];
  assign stall        = r_stall;
  assign err          = |w_err;
endmodule

// File: tb/tb_rs_tag_allocator.sv
// Bench for rs_tag_allocator: table vectors, a bitmap scoreboard model, and corner sequences.
module tb_rs_tag_allocator;
  logic       clk = 1'b0, rst;
  logic       alloc_req, alloc_is_ls, alu_rel_en, ls_rel_en, flush;
  logic [3:0] alu_rel_root, ls_rel_root;
  logic [4:0] alu_free_tag, ls_free_tag;
  logic       alu_avail, ls_avail, alloc_ok, stall, err;
  logic [3:0] alu_count, ls_count;

`ifdef TAG_ALLOC_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  always #5 clk = ~clk;

  rs_tag_allocator dut (
    .clk(clk), .rst(rst), .alloc_req(alloc_req), .alloc_is_ls(alloc_is_ls),
    .alu_rel_en(alu_rel_en), .alu_rel_root(alu_rel_root),
    .ls_rel_en(ls_rel_en), .ls_rel_root(ls_rel_root), .flush(flush),
    .alu_free_tag(alu_free_tag), .ls_free_tag(ls_free_tag),
    .alu_avail(alu_avail), .ls_avail(ls_avail), .alloc_ok(alloc_ok),
    .alu_count(alu_count), .ls_count(ls_count), .stall(stall), .err(err)
  );

  typedef struct {
    logic [4:0] atag, ltag;
    logic       aav, lav;
    logic [3:0] acnt, lcnt;
    logic       stall, err;
  } exp_t;

  typedef struct {
    logic       req, is_ls, are;
    logic [3:0] aroot;
    logic       lre;
    logic [3:0] lroot;
    logic       fl, ok;
    exp_t       e;
  } vec_t;

  exp_t        q[$];
  vec_t        tab[9];
  int          n_cmp = 0, n_bad = 0;
  logic [14:0] m_ab, m_lb;
  logic        m_err;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, want, $time);
    end
  endtask

  task automatic set_in(input logic req, is_ls, are, input logic [3:0] aroot,
                        input logic lre, input logic [3:0] lroot, input logic fl);
    alloc_req = req; alloc_is_ls = is_ls; alu_rel_en = are; alu_rel_root = aroot;
    ls_rel_en = lre; ls_rel_root = lroot; flush = fl;
  endtask

  task automatic pop_check();
    exp_t e;
    if (q.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL scoreboard: got empty queue want entry");
      return;
    end
    e = q.pop_front();
    chk("alu_free_tag", alu_free_tag, e.atag);
    chk("ls_free_tag", ls_free_tag, e.ltag);
    chk("alu_avail", alu_avail, e.aav);
    chk("ls_avail", ls_avail, e.lav);
    chk("alu_count", alu_count, e.acnt);
    chk("ls_count", ls_count, e.lcnt);
    chk("stall", stall, e.stall);
    chk("err", err, e.err);
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_alu_tag"}, alu_free_tag, 5'h00);
    chk({nm, "_ls_tag"}, ls_free_tag, 5'h10);
    chk({nm, "_avail"}, {alu_avail, ls_avail}, 2'b11);
    chk({nm, "_counts"}, {alu_count, ls_count}, 8'h00);
    chk({nm, "_stall"}, stall, 1'b0);
    chk({nm, "_err"}, err, 1'b0);
  endtask

  // {avail, lowest free root}; all-ones root and avail 0 when full
  function automatic logic [4:0] lowest(input logic [14:0] b);
    for (int i = 0; i < 15; i++) if (!b[i]) return {1'b1, 4'(i)};
    return 5'h0F;
  endfunction

  function automatic vec_t mk(input logic req, is_ls, are, input logic [3:0] aroot,
                              input logic lre, input logic [3:0] lroot, input logic fl, ok,
                              input logic [4:0] atag, ltag, input logic aav, lav,
                              input logic [3:0] acnt, lcnt, input logic st);
    vec_t v;
    v.req = req; v.is_ls = is_ls; v.are = are; v.aroot = aroot;
    v.lre = lre; v.lroot = lroot; v.fl = fl; v.ok = ok;
    v.e.atag = atag; v.e.ltag = ltag; v.e.aav = aav; v.e.lav = lav;
    v.e.acnt = acnt; v.e.lcnt = lcnt; v.e.stall = st; v.e.err = 1'b0;
    return v;
  endfunction

  task automatic apply_vec(input vec_t v, input int idx);
    set_in(v.req, v.is_ls, v.are, v.aroot, v.lre, v.lroot, v.fl);
    #1 chk($sformatf("vec%0d_alloc_ok", idx), alloc_ok, v.ok);
    q.push_back(v.e);
    @(posedge clk); #1;
    pop_check();
  endtask

  task automatic drive(input logic req, is_ls, are, input logic [3:0] aroot,
                       input logic lre, input logic [3:0] lroot, input logic fl);
    logic [4:0] fa, fs;
    logic       bad;
    int         na, nl;
    exp_t       e;
    set_in(req, is_ls, are, aroot, lre, lroot, fl);
    #1;
    fa = lowest(m_ab);
    fs = lowest(m_lb);
    chk("alloc_ok", alloc_ok, req & (is_ls ? fs[4] : fa[4]));
    bad = (req & ~(is_ls ? fs[4] : fa[4]))
        | (are & ~((aroot < 4'd15) && m_ab[aroot]))
        | (lre & ~((lroot < 4'd15) && m_lb[lroot]));
    if (fl) begin
      m_ab = '0; m_lb = '0;
    end else begin
      if (are && aroot < 4'd15 && m_ab[aroot]) m_ab[aroot] = 1'b0;
      if (lre && lroot < 4'd15 && m_lb[lroot]) m_lb[lroot] = 1'b0;
      if (req && !is_ls && fa[4]) m_ab[fa[3:0]] = 1'b1;
      if (req && is_ls && fs[4])  m_lb[fs[3:0]] = 1'b1;
    end
    m_err = m_err | (CHK & bad);
    fa = lowest(m_ab);
    fs = lowest(m_lb);
    na = $countones(m_ab);
    nl = $countones(m_lb);
    e.atag = {1'b0, fa[3:0]}; e.aav = fa[4];
    e.ltag = {1'b1, fs[3:0]}; e.lav = fs[4];
    e.acnt = 4'(na); e.lcnt = 4'(nl);
    e.stall = (15 - na < 2) || (15 - nl < 2);
    e.err = m_err;
    q.push_back(e);
    @(posedge clk); #1;
    pop_check();
  endtask

  initial begin
    tab[0] = mk(1,0,0,0,0,0,0, 1, 5'h01,5'h10,1,1,4'd1,4'd0,0);
    tab[1] = mk(1,0,0,0,0,0,0, 1, 5'h02,5'h10,1,1,4'd2,4'd0,0);
    tab[2] = mk(1,0,0,0,0,0,0, 1, 5'h03,5'h10,1,1,4'd3,4'd0,0);
    tab[3] = mk(1,0,0,0,0,0,0, 1, 5'h04,5'h10,1,1,4'd4,4'd0,0);
    tab[4] = mk(1,0,0,0,0,0,0, 1, 5'h05,5'h10,1,1,4'd5,4'd0,0);
    tab[5] = mk(1,0,1,2,0,0,0, 1, 5'h02,5'h10,1,1,4'd5,4'd0,0);
    tab[6] = mk(0,0,1,0,0,0,0, 0, 5'h00,5'h10,1,1,4'd4,4'd0,0);
    tab[7] = mk(1,1,0,0,0,0,0, 1, 5'h00,5'h11,1,1,4'd4,4'd1,0);
    tab[8] = mk(1,0,1,1,1,0,1, 1, 5'h00,5'h10,1,1,4'd0,4'd0,0);

    set_in(0,0,0,0,0,0,0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_reset("reset");

    for (int i = 0; i < 9; i++) apply_vec(tab[i], i);

    m_ab = '0; m_lb = '0; m_err = 1'b0;

    // fill the LS buffer, then one alloc too many
    for (int k = 0; k < 16; k++) begin
      drive(1,1,0,0,0,0,0);
      if (k == 12) chk("ls_fill_stall13", stall, 1'b0);
      if (k == 13) chk("ls_fill_stall14", stall, 1'b1);
      if (k == 14) chk("ls_full_tag", {ls_free_tag, ls_avail}, {5'h1F, 1'b0});
    end
    chk("ls_over_count", ls_count, 4'd15);
    drive(0,0,0,0,0,0,1);

    // illegal release of a free LS root, then flush must not clear err
    drive(0,0,0,0,1,4'd7,0);
    chk("err_after_bad_rel", err, CHK);
    drive(0,0,0,0,0,0,1);
    chk("err_after_flush", err, CHK);
    drive(0,0,1,4'd15,0,0,0);

    for (int k = 0; k < 400; k++)
      drive($urandom_range(0,3) != 0, 1'($urandom_range(0,1)),
            1'($urandom_range(0,1)), 4'($urandom_range(0,15)),
            1'($urandom_range(0,1)), 4'($urandom_range(0,15)),
            $urandom_range(0,31) == 0);

    // async reset between edges with live state
    drive(0,0,0,0,0,0,1);
    drive(1,0,0,0,0,0,0);
    drive(1,1,0,0,0,0,0);
    chk("pre_rst_counts", {alu_count, ls_count}, 8'h11);
    set_in(0,0,0,0,0,0,0);
    #3 rst = 1'b1;
    #1 chk_reset("async_rst");
    #2 rst = 1'b0;
    m_ab = '0; m_lb = '0; m_err = 1'b0;
    drive(1,0,0,0,0,0,0);

    if (q.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL scoreboard_drain: got %0d left want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/rs_tag_allocator.md
# rs_tag_allocator

Tracks occupancy of the ALU reservation-station and load/store-buffer entries and hands out the lowest free tag of each to the dispatcher each cycle. Allocation happens on dispatch and release on issue/completion; a flush frees everything. Also drives the front-end stall so the dispatcher never receives an instruction it cannot place. Sits between decoder/dispatcher and the two RS units, replacing the raw `ALUfreeStatus`/`LSfreeStatus` vectors.

## Interface
- `RS_SIZE`, 15: usable entries per unit, 1..15; root `4'hF` is never allocated.
- `ROOT_W`, 4: tag root width; full tag = `{prefix, root}`, `ROOT_W+1` bits.
- `STALL_MARGIN`, 2: stall when either unit has fewer than this many free entries.
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `alloc_req` in 1: dispatch wants an entry this cycle.
- `alloc_is_ls` in 1: 1 = LS buffer (ClassLD/ClassST), 0 = ALU.
- `alu_rel_en` in 1: ALU RS frees an entry.
- `alu_rel_root` in ROOT_W: root being freed.
- `ls_rel_en`, `ls_rel_root`: same for LS buffer.
- `flush` in 1: mispredict; free all entries.
- `alu_free_tag` out ROOT_W+1: `{1'b0, lowest free ALU root}`, registered.
- `ls_free_tag` out ROOT_W+1: `{1'b1, lowest free LS root}`, registered.
- `alu_avail`, `ls_avail` out 1: at least one free entry, registered.
- `alloc_ok` out 1: combinational, `alloc_req & (alloc_is_ls ? ls_avail : alu_avail)`.
- `alu_count`, `ls_count` out ROOT_W: occupied entries, registered.
- `stall` out 1: front-end hold, registered.
- `err` out 1: sticky illegal-operation flag (see Configuration).

## Operation
- State: two RS_SIZE-bit busy bitmaps, two occupancy counters, output registers.
- Per cycle, next bitmap = current, then: release clears `busy[rel_root]` if `rel_en` and bit set; allocation sets bit at the currently registered free root if `alloc_ok`. Both applied same cycle, same unit, different roots.
- Release of an already-free root or root ≥ RS_SIZE: ignored. Cannot collide with allocation; the allocated root is free by definition.
- Alloc when unit unavailable: ignored, `alloc_ok` = 0.
- Counters: +1 on alloc, −1 on valid release, unchanged when both; never wrap.
- Free tag = priority encode (lowest index) of ~next bitmap; if none free, root = all-ones and `avail` = 0. `{1, 4'hF}` equals tagFree; never presented with avail = 1.
- `stall` = (RS_SIZE − next alu count < STALL_MARGIN) | (same for LS).
- `flush`: highest priority; same-cycle alloc/release discarded; next cycle bitmaps clear, counts 0, free tags root 0, avail 1, stall 0. `err` not cleared.

## Timing
- Reset values: bitmaps 0, `alu_free_tag` = 5'b00000, `ls_free_tag` = 5'b10000, `alu_avail` = `ls_avail` = 1, counts 0, `stall` 0, `err` 0.
- Alloc/release at edge t is reflected in tags, avail, counts and stall after edge t; a root freed at t is allocatable at t+1.
- Back-to-back allocs to one unit each cycle yield roots 0,1,2,… without bubbles.
- `STALL_MARGIN` ≥ 2 covers the one-cycle dispatcher register in flight when stall rises.
- `rst` mid-operation: all state to reset values immediately, independent of `clk`.

## Configuration
- `TAG_ALLOC_CHECK_EN` defined: `err` sets (sticky until `rst`) on alloc_req with unit unavailable, release of a free root, or release root ≥ RS_SIZE.
- Not defined: `err` tied 0, no check logic; illegal operations still ignored as above.

## Test plan
- Reset, 3 ALU allocs back-to-back -> `alu_free_tag` 0x00,0x01,0x02 presented; then `alu_count` = 3, `alu_free_tag` = 0x03.
- Fill LS (15 allocs) -> `stall` rises when count reaches 14, `ls_avail` = 0, `ls_free_tag` = 0x1F at 15; 16th alloc gives `alloc_ok` = 0, count stays 15.
- ALU roots 0–4 busy, release root 2 while allocating -> alloc takes root 5; next `alu_free_tag` = 0x02, count unchanged at 5.
- Flush with concurrent alloc and release -> next cycle both counts 0, tags 0x00/0x10, stall 0.
- With `TAG_ALLOC_CHECK_EN`, release free LS root 7 -> `err` = 1 and stays 1 through flush; cleared only by `rst`.
- Assert `rst` between edges with counts nonzero -> all outputs at reset values before next edge.
